// File: rtl/demux_stream.sv
// 1-to-2 registered stream demultiplexer: each accepted word is steered to port A
// (s_sel=0) or port B (s_sel=1). Each port has a one-entry output register and a transfer counter.

module demux_stream_port #(
  parameter int WIDTH = 1,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNTW-1:0]  cnt
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             xfer;

  // A load on the same cycle as a drain keeps the port FULL with the new word.
  always_comb begin
    xfer    = (state_q == FULL) & ready;
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = FULL;
      data_d  = load_data;
    end else if (xfer) begin
      state_d = EMPTY;
    end
    if (xfer) cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid = (state_q == FULL);
  assign data  = data_q;
  assign cnt   = cnt_q;
endmodule

module demux_stream #(
  parameter int WIDTH = 1,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_sel,
  input  logic [WIDTH-1:0] s_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [CNTW-1:0]  a_cnt,
  output logic [CNTW-1:0]  b_cnt
);
  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0]            port_rdy, port_vld, port_load;
  logic [NUM_PORTS-1:0][WIDTH-1:0] port_data;
  logic [NUM_PORTS-1:0][CNTW-1:0]  port_cnt;
  logic                            accept;

  assign port_rdy = {b_ready, a_ready};

  // Only comb path: s_sel and consumer readys into s_ready; data is always registered.
  assign s_ready = ~port_vld[s_sel] | port_rdy[s_sel];
  assign accept  = s_valid & s_ready;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign port_load[p] = accept & (s_sel == 1'(p));

    demux_stream_port #(.WIDTH(WIDTH), .CNTW(CNTW)) u_port (
      .clk       (clk),
      .rst       (rst),
      .load      (port_load[p]),
      .load_data (s_data),
      .ready     (port_rdy[p]),
      .valid     (port_vld[p]),
      .data      (port_data[p]),
      .cnt       (port_cnt[p])
    );
  end

  assign a_valid = port_vld[0];
  assign a_data  = port_data[0];
  assign a_cnt   = port_cnt[0];
  assign b_valid = port_vld[1];
  assign b_data  = port_data[1];
  assign b_cnt   = port_cnt[1];
endmodule
